// File: rtl/npu_sched_pkg.sv
// rtl/npu_sched_pkg.sv - shared types and defaults for the NPU instruction scheduler
package npu_sched_pkg;

    localparam int NPU_INST_W        = 128;
    localparam int NPU_SCHED_DEPTH   = 8;
    localparam int NPU_SCHED_TIMEOUT = 2000000;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } sched_state_t;

endpackage

// File: rtl/npu_inst_fifo.sv
// rtl/npu_inst_fifo.sv - show-ahead synchronous instruction FIFO
module npu_inst_fifo
    import npu_sched_pkg::*;
#(
    parameter int WIDTH = NPU_INST_W,
    parameter int DEPTH = NPU_SCHED_DEPTH
) (
    input  logic                     npu_inst_clk,
    input  logic                     npu_inst_rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care until the level says otherwise
    always_ff @(posedge npu_inst_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; level tracks occupancy so full/empty need no extra bit
    always_ff @(posedge npu_inst_clk or negedge npu_inst_rst_n) begin
        if (!npu_inst_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/npu_inst_sched.sv
// rtl/npu_inst_sched.sv - arbitrates host/sequencer instructions and issues them to the NPU (watchdog: NPU_SCHED_TIMEOUT_EN)
module npu_inst_sched
    import npu_sched_pkg::*;
#(
    parameter int DEPTH   = NPU_SCHED_DEPTH,
    parameter int TIMEOUT = NPU_SCHED_TIMEOUT
) (
    input  logic                     npu_inst_clk,
    input  logic                     npu_inst_rst_n,
    input  logic [NPU_INST_W-1:0]    src0_inst,
    input  logic                     src0_inst_en,
    input  logic [NPU_INST_W-1:0]    src1_inst,
    input  logic                     src1_inst_valid,
    output logic                     src1_inst_ready,
    output logic [NPU_INST_W-1:0]    npu_inst,
    output logic                     npu_inst_start,
    input  logic                     npu_inst_done,
    output logic                     sched_busy,
    output logic                     sched_drop,
    output logic                     sched_timeout,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [NPU_INST_W-1:0] push_data;
    logic [NPU_INST_W-1:0] head;
    sched_state_t          state;

    // The host path cannot be stalled, so the sequencer only gets a slot the host leaves free
    assign src1_inst_ready = !full && !src0_inst_en;
    assign pop             = (state == IDLE) && !empty;
    assign sched_busy      = (state == WAIT);

    // Single write port: host strobe wins, sequencer fills otherwise idle slots
    always_comb begin
        push      = 1'b0;
        push_data = src1_inst;
        if (src0_inst_en) begin
            push      = !full;
            push_data = src0_inst;
        end else if (src1_inst_valid && src1_inst_ready) begin
            push      = 1'b1;
        end
    end

    npu_inst_fifo #(
        .WIDTH (NPU_INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .npu_inst_clk   (npu_inst_clk),
        .npu_inst_rst_n (npu_inst_rst_n),
        .push           (push),
        .push_data      (push_data),
        .pop            (pop),
        .head           (head),
        .level          (fifo_level),
        .full           (full),
        .empty          (empty)
    );

    // Flag a host instruction that arrived while the FIFO had no room
    always_ff @(posedge npu_inst_clk or negedge npu_inst_rst_n) begin
        if (!npu_inst_rst_n) begin
            sched_drop <= 1'b0;
        end else begin
            sched_drop <= src0_inst_en && full;
        end
    end

`ifdef NPU_SCHED_TIMEOUT_EN
    localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   WD_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wd_cnt;
    logic          wd_expired;

    assign wd_expired = (wd_cnt == WD_LAST);

    // Issue FSM with watchdog: done has precedence over an expiry in the same cycle
    always_ff @(posedge npu_inst_clk or negedge npu_inst_rst_n) begin
        if (!npu_inst_rst_n) begin
            state          <= IDLE;
            npu_inst       <= '0;
            npu_inst_start <= 1'b0;
            sched_timeout  <= 1'b0;
            wd_cnt         <= '0;
        end else begin
            npu_inst_start <= 1'b0;
            sched_timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        npu_inst       <= head;
                        npu_inst_start <= 1'b1;
                        wd_cnt         <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (npu_inst_done) begin
                        wd_cnt <= '0;
                        state  <= IDLE;
                    end else if (wd_expired) begin
                        sched_timeout <= 1'b1;
                        wd_cnt        <= '0;
                        state         <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign sched_timeout  = 1'b0;

    // Issue FSM without watchdog: an instruction stays outstanding until done
    always_ff @(posedge npu_inst_clk or negedge npu_inst_rst_n) begin
        if (!npu_inst_rst_n) begin
            state          <= IDLE;
            npu_inst       <= '0;
            npu_inst_start <= 1'b0;
        end else begin
            npu_inst_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        npu_inst       <= head;
                        npu_inst_start <= 1'b1;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (npu_inst_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: doc/npu_inst_sched.md
# npu_inst_sched

Instruction scheduler between the instruction sources and the NPU core. It accepts 128-bit instructions from two sources: the host path, which comes from the 32-bit-part joiner, and a local sequencer. It arbitrates them into one FIFO and issues them to the NPU one at a time with a start/done handshake. An optional watchdog recovers from a missing done.

## Interface
- DEPTH, 8: FIFO entries; must be a power of 2, ≥2.
- TIMEOUT, 2000000: watchdog limit in cycles (40 ms at 50 MHz).

Ports, clock and reset first:
- npu_inst_clk  in  1  clock.
- npu_inst_rst_n  in  1  reset; asynchronous, active-low.
- src0_inst  in  128  host instruction.
- src0_inst_en  in  1  one-cycle strobe; no backpressure.
- src1_inst  in  128  sequencer instruction.
- src1_inst_valid  in  1  sequencer request; held until accepted.
- src1_inst_ready  out  1  sequencer accept.
- npu_inst  out  128  instruction to NPU.
- npu_inst_start  out  1  one-cycle issue pulse.
- npu_inst_done  in  1  one-cycle completion pulse from NPU.
- sched_busy  out  1  high while an instruction is outstanding.
- sched_drop  out  1  pulse: src0 instruction lost because the FIFO was full.
- sched_timeout  out  1  pulse: watchdog fired.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **Arbitration:** at most one FIFO write per cycle. src0 has strict priority.
  - src0_inst_en and not full → write src0.
  - src0_inst_en and full → sched_drop pulses; nothing is written.
- **src1 handshake:** src1_inst_ready = !full && !src0_inst_en. The value is combinational. A transfer occurs when valid && ready.
- **Full condition:** full = (fifo_level == DEPTH). A push is blocked when full even if a pop happens in the same cycle.
- **Pointers:** both pointers are $clog2(DEPTH) bits and wrap naturally.
- **Simultaneous push and pop:** leaves fifo_level unchanged.
- **FSM state IDLE:** if fifo_level != 0:
  - register npu_inst <= head;
  - npu_inst_start <= 1;
  - pop;
  - go to WAIT.
- **FSM state WAIT:** sched_busy = 1. The watchdog counter increments each cycle.
  - npu_inst_done → clear counter, go to IDLE.
  - counter == TIMEOUT-1 without done → sched_timeout pulses, clear counter, go to IDLE.
  - Done and timeout in the same cycle → done wins; no timeout pulse.
- **Done outside WAIT:** ignored, including in the start cycle's IDLE→WAIT edge.
- **npu_inst hold:** holds its value until the next issue.
- **Reset:** all outputs, state, counter and pointers clear to 0. The FIFO empties.
  - npu_inst = 0 and npu_inst_start = 0.
  - src1_inst_ready follows its combinational definition (1 after reset unless src0_inst_en).
  - Reset mid-WAIT abandons the outstanding instruction silently.

## Timing
- **Issue latency:** a write accepted at edge t is visible in fifo_level after t. If the FSM is IDLE, npu_inst_start is high in the cycle following edge t+1.
- **Pulse width:** npu_inst_start is high for exactly one cycle. npu_inst is valid in that cycle and held afterward.
- **Back-to-back issue:** after done is sampled at edge d, the FSM is IDLE. The next start rises after edge d+1, giving a minimum gap of 1 idle cycle.
- **Pulse alignment:** sched_drop and sched_timeout are registered and last one cycle. sched_drop follows the offending strobe by one cycle.

## Configuration
- **NPU_SCHED_TIMEOUT_EN defined:** the watchdog counter, TIMEOUT comparison and sched_timeout logic are compiled in as described above.
- **NPU_SCHED_TIMEOUT_EN undefined:**
  - WAIT exits only on npu_inst_done.
  - sched_timeout is tied to 0.
  - No counter is instantiated. TIMEOUT is unused.

## Structure
- **Package npu_sched_pkg:**
  - state encoding (IDLE=0, WAIT=1);
  - instruction width constant NPU_INST_W=128;
  - default DEPTH/TIMEOUT localparams.
- **Sub-module npu_inst_fifo:**
  - synchronous FIFO with width NPU_INST_W and DEPTH;
  - push/pop/level/full/empty;
  - first-word data visible at the head without a read cycle.
- **Top level:** arbitration, FSM and watchdog live in npu_inst_sched.

## Test plan
1. **Single issue:** reset, then src0 strobe with 128'h0001_0002_0003_0004 → start pulses 2 cycles later with that npu_inst; busy holds until a done 10 cycles later; fifo_level returns to 0.
2. **Ordering:** src0 and src1_valid asserted in the same cycle (A, B) → src1_ready low that cycle; B accepted the next cycle; issue order is A then B, each after its done.
3. **Overflow:** DEPTH=8; NPU held in WAIT; 10 src0 strobes → fifo_level=8; sched_drop pulses exactly twice; src1_ready=0 while full.
4. **Watchdog:** TIMEOUT=16, no done → sched_timeout pulses 16 cycles after start; next queued instruction issues; with the macro undefined, busy stays high indefinitely.
5. **Done/timeout collision:** done on the final watchdog cycle → no sched_timeout pulse. Done pulsed while IDLE → ignored, with no state change.
6. **Reset mid-operation:** reset asserted in WAIT with 3 queued → all outputs 0 immediately (async); fifo_level=0; no start after release until a new write.
